// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the writeback port arbiter.
// Holds the port count, request/port bundles and port-mask helpers.
package wb_arb_pkg;

    localparam int NUM_WB_PORTS = 3;
    localparam int WB_ADDR_W    = 6;
    localparam int WB_DATA_W    = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef struct packed {
        logic                 en;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_port_t;

    // Number of enabled ports in the mask.
    function automatic logic [1:0] port_count(input logic [2:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
    endfunction

    // Position of port p among the enabled ports (0 = first enabled).
    function automatic int port_rank(input logic [2:0] m, input int p);
        int r;
        r = 0;
        for (int i = 0; i < NUM_WB_PORTS; i++) begin
            if (i < p && m[i]) begin
                r++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin picker: grants up to count_i valid entries starting at ptr_i.
// Ports: valid_i mask, ptr_i start index, count_i grant budget; grant_o, last_o, any_o.
module wb_rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid_i,
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [1:0]       count_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] last_o,
    output logic             any_o
);

    int idx;
    int taken;

    always_comb begin
        grant_o = '0;
        last_o  = ptr_i;
        any_o   = 1'b0;
        taken   = 0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (valid_i[idx] && taken < int'(count_i)) begin
                grant_o[idx] = 1'b1;
                last_o       = PTR_W'(idx);
                any_o        = 1'b1;
                taken        = taken + 1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: grants up to three register writes per cycle, round-robin.
// Ports: req_* handshakes in, port_mask, three registered write ports, rr_ptr.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = WB_DATA_W,
    parameter int ADDR_WIDTH = WB_ADDR_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [2:0]                           port_mask,
    output logic                                 write_En,
    output logic [ADDR_WIDTH-1:0]                write_Addr,
    output logic [DATA_WIDTH-1:0]                write_Data,
    output logic                                 write_En_2,
    output logic [ADDR_WIDTH-1:0]                write_Addr_2,
    output logic [DATA_WIDTH-1:0]                write_Data_2,
    output logic                                 write_En_3,
    output logic [ADDR_WIDTH-1:0]                write_Addr_3,
    output logic [DATA_WIDTH-1:0]                write_Data_3,
    output logic [$clog2(NUM_REQ)-1:0]           rr_ptr
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]  rr_q, rr_d;
    wb_port_t       port_q [NUM_WB_PORTS];
    wb_port_t       port_d [NUM_WB_PORTS];

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] zacc;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      last;
    logic               any;
    logic [1:0]         budget;
    logic               dup;
    int                 ie, je, ia, slot;

    function automatic int wrap(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    // A nonzero request is eligible only if no earlier request in search
    // order targets the same register; the earlier one either wins or the
    // port budget ran out before it, so the later one can never be granted.
    always_comb begin
        elig = '0;
        zacc = '0;
        dup  = 1'b0;
        ie   = 0;
        je   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ie  = wrap(int'(rr_q) + k);
            dup = 1'b0;
            for (int j = 0; j < k; j++) begin
                je = wrap(int'(rr_q) + j);
                if (req_valid[je] && req_addr[je] == req_addr[ie]) begin
                    dup = 1'b1;
                end
            end
            if (req_valid[ie]) begin
                if (req_addr[ie] == '0) begin
                    zacc[ie] = 1'b1;
                end else begin
                    elig[ie] = !dup;
                end
            end
        end
    end

    assign budget = rst ? 2'd0 : port_count(port_mask);

    wb_rr_picker #(
        .N     (NUM_REQ),
        .PTR_W (PW)
    ) u_picker (
        .valid_i (elig),
        .ptr_i   (rr_q),
        .count_i (budget),
        .grant_o (grant),
        .last_o  (last),
        .any_o   (any)
    );

    assign req_ready = rst ? '0 : (grant | zacc);

    // k-th grant in search order lands on the k-th enabled port.
    always_comb begin
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            port_d[p]    = port_q[p];
            port_d[p].en = 1'b0;
        end
        slot = 0;
        ia   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ia = wrap(int'(rr_q) + k);
            if (grant[ia]) begin
                for (int p = 0; p < NUM_WB_PORTS; p++) begin
                    if (port_mask[p] && port_rank(port_mask, p) == slot) begin
                        port_d[p] = '{en: 1'b1,
                                      addr: req_addr[ia],
                                      data: req_data[ia]};
                    end
                end
                slot = slot + 1;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (any) begin
            rr_d = (int'(last) == NUM_REQ - 1) ? '0 : last + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
                port_q[p] <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
                port_q[p] <= port_d[p];
            end
        end
    end

    // Enables are masked during reset so a write registered just before
    // reset never reaches the register file.
    assign write_En     = port_q[0].en && !rst;
    assign write_Addr   = port_q[0].addr;
    assign write_Data   = port_q[0].data;
    assign write_En_2   = port_q[1].en && !rst;
    assign write_Addr_2 = port_q[1].addr;
    assign write_Data_2 = port_q[1].data;
    assign write_En_3   = port_q[2].en && !rst;
    assign write_Addr_3 = port_q[2].addr;
    assign write_Data_3 = port_q[2].data;
    assign rr_ptr       = rr_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a write scoreboard.
// Stimulus pushes expected port writes; a negedge monitor pops and compares.
module tb_wb_port_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0][5:0]  req_addr;
    logic [3:0][31:0] req_data;
    logic [3:0]       req_ready;
    logic [2:0]       port_mask;
    logic             write_En, write_En_2, write_En_3;
    logic [5:0]       write_Addr, write_Addr_2, write_Addr_3;
    logic [31:0]      write_Data, write_Data_2, write_Data_3;
    logic [1:0]       rr_ptr;

    typedef struct {
        int          port;
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rf [64];
    int          n_chk = 0;
    int          n_fail = 0;

    wb_port_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .port_mask    (port_mask),
        .write_En     (write_En),
        .write_Addr   (write_Addr),
        .write_Data   (write_Data),
        .write_En_2   (write_En_2),
        .write_Addr_2 (write_Addr_2),
        .write_Data_2 (write_Data_2),
        .write_En_3   (write_En_3),
        .write_Addr_3 (write_Addr_3),
        .write_Data_3 (write_Data_3),
        .rr_ptr       (rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int p, input logic [5:0] a,
                        input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] a,
                           input logic [31:0] d);
        req_addr[i] = a;
        req_data[i] = d;
    endtask

    // Monitor: every enabled port must match the next expected write.
    always @(negedge clk) begin
        logic        en [3];
        logic [5:0]  ad [3];
        logic [31:0] dt [3];
        exp_t        e;
        en[0] = write_En;   ad[0] = write_Addr;   dt[0] = write_Data;
        en[1] = write_En_2; ad[1] = write_Addr_2; dt[1] = write_Data_2;
        en[2] = write_En_3; ad[2] = write_Addr_3; dt[2] = write_Data_3;
        for (int p = 0; p < 3; p++) begin
            if (en[p] === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: port %0d addr %0h data %0h expected none",
                             p + 1, ad[p], dt[p]);
                end else begin
                    e = sb.pop_front();
                    chk("sb_port", 64'(p + 1), 64'(e.port));
                    chk("sb_addr", 64'(ad[p]), 64'(e.addr));
                    chk("sb_data", 64'(dt[p]), 64'(e.data));
                    rf[ad[p]] = dt[p];
                end
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_en"}, 64'({write_En, write_En_2, write_En_3}), 64'd0);
        chk({tag, "_addr"}, 64'({write_Addr, write_Addr_2, write_Addr_3}), 64'd0);
        chk({tag, "_data"}, 64'({write_Data, write_Data_2, write_Data_3}), 64'd0);
        chk({tag, "_rr"}, 64'(rr_ptr), 64'd0);
    endtask

    initial begin
        int         start;
        int         gc [4];
        int         wt [4];
        int         maxw;
        logic [3:0] er;

        for (int i = 0; i < 64; i++) rf[i] = '0;

        // Reset with four requesters pending on registers 5..8.
        rst       = 1'b1;
        port_mask = 3'b111;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, 6'(5 + i), 32'hD000_0000 + i);
        cyc();
        #1 chk("rst_ready", 64'(req_ready), 64'b0000);
        cyc();
        rst = 1'b0;
        #1;
        chk_zero_outputs("reset_state");
        chk("first_ready", 64'(req_ready), 64'b0111);
        push(1, 6'd5, 32'hD000_0000);
        push(2, 6'd6, 32'hD000_0001);
        push(3, 6'd7, 32'hD000_0002);
        cyc();
        req_valid = 4'b1000;
        #1;
        chk("t1_rr3", 64'(rr_ptr), 64'd3);
        chk("t1_ready_req3", 64'(req_ready), 64'b1000);
        push(1, 6'd8, 32'hD000_0003);
        cyc();
        req_valid = 4'b0000;
        #1 chk("t1_rr_wrap", 64'(rr_ptr), 64'd0);

        // Same destination from req1 and req2.
        cyc();
        set_req(1, 6'd12, 32'hA1A1_0001);
        set_req(2, 6'd12, 32'hA2A2_0002);
        req_valid = 4'b0110;
        #1 chk("t2_ready_dup", 64'(req_ready), 64'b0010);
        push(1, 6'd12, 32'hA1A1_0001);
        cyc();
        req_valid = 4'b0100;
        #1;
        chk("t2_rr2", 64'(rr_ptr), 64'd2);
        chk("t2_ready_req2", 64'(req_ready), 64'b0100);
        push(1, 6'd12, 32'hA2A2_0002);
        cyc();
        req_valid = 4'b0000;
        #1 chk("t2_rr3", 64'(rr_ptr), 64'd3);

        // Zero-address request alongside a real one.
        set_req(0, 6'd0, 32'hBBBB_0000);
        set_req(1, 6'd9, 32'hBBBB_0001);
        req_valid = 4'b0011;
        #1 chk("t3_ready_zero", 64'(req_ready), 64'b0011);
        push(1, 6'd9, 32'hBBBB_0001);
        cyc();
        req_valid = 4'b0000;
        #1 chk("t3_rr2", 64'(rr_ptr), 64'd2);

        // Only port 2 enabled: one grant per cycle on write_En_2.
        port_mask = 3'b010;
        set_req(0, 6'd30, 32'hC000_0000);
        set_req(1, 6'd31, 32'hC000_0001);
        set_req(2, 6'd32, 32'hC000_0002);
        req_valid = 4'b0111;
        #1 chk("t4_ready_a", 64'(req_ready), 64'b0100);
        push(2, 6'd32, 32'hC000_0002);
        cyc();
        req_valid = 4'b0011;
        #1 chk("t4_ready_b", 64'(req_ready), 64'b0001);
        push(2, 6'd30, 32'hC000_0000);
        cyc();
        req_valid = 4'b0010;
        #1 chk("t4_ready_c", 64'(req_ready), 64'b0010);
        push(2, 6'd31, 32'hC000_0001);
        cyc();
        req_valid = 4'b0000;
        port_mask = 3'b111;
        #1 chk("t4_rr2", 64'(rr_ptr), 64'd2);

        // Port mask zero: only zero-address accepts.
        set_req(0, 6'd0, 32'h0);
        set_req(3, 6'd44, 32'hEE00_0044);
        port_mask = 3'b000;
        req_valid = 4'b1001;
        #1 chk("mask0_ready", 64'(req_ready), 64'b0001);
        cyc();
        req_valid = 4'b0000;
        port_mask = 3'b111;
        #1 chk("mask0_rr_hold", 64'(rr_ptr), 64'd2);

        // Sustained traffic: three grants per cycle rotating by three.
        for (int i = 0; i < 4; i++) begin
            set_req(i, 6'(20 + i), 32'hE000_0000 + i);
            gc[i] = 0;
            wt[i] = 0;
        end
        maxw      = 0;
        start     = 2;
        req_valid = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            #1;
            er = 4'b1111;
            er[(start + 3) % 4] = 1'b0;
            chk("t5_ready", 64'(req_ready), 64'(er));
            for (int s = 0; s < 3; s++) begin
                int r;
                r = (start + s) % 4;
                push(s + 1, 6'(20 + r), 32'hE000_0000 + r);
            end
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) begin
                    gc[i]++;
                    wt[i] = 0;
                end else begin
                    wt[i]++;
                    if (wt[i] > maxw) maxw = wt[i];
                end
            end
            start = (start + 3) % 4;
            cyc();
        end
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            chk("t5_min_grants", 64'(gc[i] >= 29), 64'd1);
        end
        chk("t5_max_wait", 64'(maxw <= 2), 64'd1);
        #1 chk("t5_rr", 64'(rr_ptr), 64'(start));

        // Accept, then reset on the following cycle: write is dropped.
        cyc();
        set_req(0, 6'd40, 32'hF000_0040);
        req_valid = 4'b0001;
        #1 chk("t6_ready", 64'(req_ready), 64'b0001);
        cyc();
        rst       = 1'b1;
        req_valid = 4'b0000;
        #1 chk("t6_no_en", 64'({write_En, write_En_2, write_En_3}), 64'd0);
        cyc();
        rst = 1'b0;
        #1 chk_zero_outputs("t6_after_rst");

        cyc();
        cyc();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("rf12_last", 64'(rf[12]), 64'(32'hA2A2_0002));
        chk("rf9", 64'(rf[9]), 64'(32'hBBBB_0001));
        chk("rf40_dropped", 64'(rf[40]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
